// File: rtl/apb_spi_ctrl_pkg.sv
// Shared constants for the APB-to-SPI controller: register offsets,
// STATUS/CTRL bit positions and sequencer state encodings.
package apb_spi_ctrl_pkg;

  localparam int BYTE_W = 8;

  // Word offsets (paddr[3:2])
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_FULL  = 2;
  localparam int ST_RX_EMPTY = 3;
  localparam int ST_SEQ_BUSY = 4;

  // CTRL bit positions
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;

  // Sequencer state encodings
  localparam logic [1:0] SEQ_IDLE      = 2'd0;
  localparam logic [1:0] SEQ_START     = 2'd1;
  localparam logic [1:0] SEQ_WAIT_BUSY = 2'd2;
  localparam logic [1:0] SEQ_WAIT_DONE = 2'd3;

endpackage

// File: rtl/apb_spi_ctrl_if.sv
// Bus bundle for apb_spi_ctrl: APB3 slave side, interrupt and the
// start/busy handshake towards the SPI master driver.
interface apb_spi_ctrl_if;
  logic        psel_i;
  logic        penable_i;
  logic        pwrite_i;
  logic [3:0]  paddr_bi;
  logic [31:0] pwdata_bi;
  logic [31:0] prdata_bo;
  logic        pready_o;
  logic        pslverr_o;
  logic        irq_o;
  logic        spi_start_o;
  logic [7:0]  spi_data_bo;
  logic        spi_busy_i;
  logic [7:0]  spi_rdata_bi;

  modport slave (
    input  psel_i, penable_i, pwrite_i, paddr_bi, pwdata_bi,
    output prdata_bo, pready_o, pslverr_o, irq_o,
    output spi_start_o, spi_data_bo,
    input  spi_busy_i, spi_rdata_bi
  );

  modport master (
    output psel_i, penable_i, pwrite_i, paddr_bi, pwdata_bi,
    input  prdata_bo, pready_o, pslverr_o, irq_o,
    input  spi_start_o, spi_data_bo,
    output spi_busy_i, spi_rdata_bi
  );
endinterface

// File: rtl/apb_spi_ctrl_sync_fifo.sv
// Small synchronous FIFO with a combinational head (first-word fall-through).
// Push to full and pop from empty are ignored, judged on pre-edge state.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_reg == DEPTH_C);
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign head    = mem_reg[rd_ptr_reg];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Storage array; no reset so it maps onto plain memory.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_reg[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally at a power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/apb_spi_ctrl.sv
// APB3 slave feeding a byte-wide SPI master driver through TX/RX FIFOs.
// One start/busy handshake per byte; RX space is reserved before each start.
module apb_spi_ctrl
  import apb_spi_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  apb_spi_ctrl_if.slave  bus
);

  logic        access;
  logic [1:0]  word;
  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  tx_head, rx_head;
  logic [PTR_W:0] tx_count, rx_count;
  logic [1:0]  state_reg, state_next;
  logic [1:0]  ctrl_reg;
  logic [7:0]  spi_data_reg;
  logic        irq_reg;
  logic        seq_busy;
  logic        seq_go;
  logic [4:0]  status;
  logic [31:0] prdata;
  logic        pslverr;
  logic        unused_bits;

  assign access   = bus.psel_i & bus.penable_i;
  assign word     = bus.paddr_bi[3:2];
  assign seq_busy = (state_reg != SEQ_IDLE);
  assign seq_go   = ctrl_reg[CTRL_ENABLE] & ~tx_empty & ~rx_full;
  assign tx_push  = access & bus.pwrite_i & (word == REG_TXDATA);
  assign rx_pop   = access & ~bus.pwrite_i & (word == REG_RXDATA);

  assign unused_bits = ^{bus.paddr_bi[1:0], bus.pwdata_bi[31:8], tx_count, rx_count};

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_tx_fifo (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .push(tx_push), .din(bus.pwdata_bi[7:0]), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH), .PTR_W(PTR_W)) u_rx_fifo (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .push(rx_push), .din(bus.spi_rdata_bi), .pop(rx_pop),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // Sequencer state register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_reg <= SEQ_IDLE;
    else          state_reg <= state_next;
  end

  // Sequencer next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SEQ_IDLE:      if (seq_go) state_next = SEQ_START;
      SEQ_START:     state_next = SEQ_WAIT_BUSY;
      SEQ_WAIT_BUSY: if (bus.spi_busy_i) state_next = SEQ_WAIT_DONE;
      SEQ_WAIT_DONE: if (!bus.spi_busy_i) state_next = SEQ_IDLE;
      default:       state_next = SEQ_IDLE;
    endcase
  end

  // Sequencer outputs: TX pop on launch, start pulse, RX push on completion.
  always_comb begin
    tx_pop          = (state_reg == SEQ_IDLE) & seq_go;
    bus.spi_start_o = (state_reg == SEQ_START);
    rx_push         = (state_reg == SEQ_WAIT_DONE) & ~bus.spi_busy_i;
  end

  // Byte to driver, CTRL register and registered interrupt.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      spi_data_reg <= '0;
      ctrl_reg     <= '0;
      irq_reg      <= 1'b0;
    end else begin
      if (tx_pop) spi_data_reg <= tx_head;
      if (access && bus.pwrite_i && word == REG_CTRL) ctrl_reg <= bus.pwdata_bi[1:0];
      irq_reg <= ctrl_reg[CTRL_IRQ_EN] & (~rx_empty | (tx_empty & ~seq_busy));
    end
  end

  // Status vector as seen by the bus.
  always_comb begin
    status              = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_SEQ_BUSY] = seq_busy;
  end

  // Read data and error response, driven only during an access phase.
  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    if (access) begin
      case (word)
        REG_TXDATA: pslverr = bus.pwrite_i & tx_full;
        REG_RXDATA: if (!bus.pwrite_i) begin
          if (rx_empty) pslverr = 1'b1;
          else          prdata  = {24'b0, rx_head};
        end
        REG_STATUS: if (!bus.pwrite_i) prdata = {27'b0, status};
        default:    if (!bus.pwrite_i) prdata = {30'b0, ctrl_reg};
      endcase
    end
  end

  assign bus.prdata_bo   = prdata;
  assign bus.pslverr_o   = pslverr;
  assign bus.pready_o    = 1'b1;
  assign bus.irq_o       = irq_reg;
  assign bus.spi_data_bo = spi_data_reg;

endmodule
